conv_batch_sched: RTL and testbench
===================================

Name: conv_batch_sched

Overview:
Batch scheduler for the binary 3x3 convolution engine. It accepts a host job-batch command and launches the engine once per job through the engine's run/busy handshake. It relocates the engine's SRAM read/write addresses by a per-job base, so several images in the shared input/output SRAM are processed without host intervention. It also provides a completion pulse, timeout/abort status and a job counter to the host.

Parameters:
ADDR_W, 12, SRAM address width (engine and SRAM)
DATA_W, 16, SRAM write data width
JOB_W, 4, job count width (max 15 jobs per batch)
ACK_MAX, 4, cycles allowed from eng_run to eng_busy rising
TIMEOUT, 2048, max cycles eng_busy may stay high per job

Ports:
clk  in  1  clock
reset_b  in  1  async active-low reset
host_run  in  1  batch start pulse
host_abort  in  1  request abort of batch in progress
host_busy  out  1  batch in progress
cfg_job_count  in  JOB_W  jobs in batch, sampled on accepted host_run
cfg_in_base  in  ADDR_W  input base of job 0
cfg_out_base  in  ADDR_W  output base of job 0
cfg_in_stride  in  ADDR_W  input base increment per job
cfg_out_stride  in  ADDR_W  output base increment per job
eng_run  out  1  engine start pulse
eng_busy  in  1  engine busy
eng_read_address  in  ADDR_W  engine-relative read address
eng_write_address  in  ADDR_W  engine-relative write address
eng_write_enable  in  1  engine write strobe
eng_write_data  in  DATA_W  engine write data
sram_read_address  out  ADDR_W  eng_read_address + cur_in_base, mod 2^ADDR_W
sram_write_address  out  ADDR_W  eng_write_address + cur_out_base, mod 2^ADDR_W
sram_write_enable  out  1  eng_write_enable gated by state != IDLE
sram_write_data  out  DATA_W  eng_write_data passthrough
job_idx  out  JOB_W  index of current/last job
batch_done  out  1  one-cycle completion pulse
err_timeout  out  1  sticky: ack or run timeout occurred
err_abort  out  1  sticky: batch ended by host_abort

Behaviour:
- Reset values: all outputs 0, state IDLE, cur bases 0, counters 0.
- The clock and reset are fixed as stated: one clock `clk`; reset `reset_b` is asynchronous and active-low.
- The address/data path is combinational (0 latency) so engine read timing is unchanged. Base registers change only in NEXT, never while the engine is busy.
- FSM states: IDLE, LAUNCH, WAIT_ACK, RUN, NEXT, DONE.
- IDLE:
  - host_run=1 is accepted. It latches the cfg_* fields, sets cur_in_base=cfg_in_base, cur_out_base=cfg_out_base, job_idx=0, clears err_timeout/err_abort, sets host_busy=1 and goes to LAUNCH.
  - If cfg_job_count==0, go directly to DONE instead.
  - host_run in any other state is ignored.
- LAUNCH: eng_run=1 for exactly this cycle, then go to WAIT_ACK with ack counter cleared.
- WAIT_ACK:
  - eng_busy=1 -> RUN, run counter cleared.
  - Ack counter reaching ACK_MAX -> set err_timeout, go to DONE.
- RUN:
  - eng_busy falls to 0 -> NEXT.
  - Run counter reaching TIMEOUT-1 with eng_busy still 1 -> set err_timeout, go to DONE.
  - host_abort=1 sets an abort-pending flag. The engine is not interrupted; on eng_busy falling the FSM goes to DONE with err_abort=1.
  - host_abort in LAUNCH/WAIT_ACK also sets the pending flag and takes effect at the end of that job.
- NEXT (1 cycle):
  - If job_idx+1 == latched job count, or abort pending -> DONE.
  - Otherwise job_idx+=1, cur_in_base+=in_stride, cur_out_base+=out_stride (wrap mod 2^ADDR_W), then LAUNCH.
- DONE (1 cycle): batch_done=1, host_busy=0 at the next edge, return to IDLE. job_idx holds the last job index.
- Bus gating: sram_write_enable=0 in IDLE regardless of eng_write_enable, which blocks stray engine writes.
- Simultaneous events:
  - Timeout and busy-fall in the same cycle: busy-fall wins, no error.
  - host_abort and busy-fall in the same cycle: abort honoured (DONE, err_abort).
- Reset mid-batch: immediate return to IDLE, all outputs cleared. The engine is reset by the same reset_b.

Test Plan:
- Batch of 3 jobs: in_base=0x000, in_stride=0x020, out_base=0x100, out_stride=0x010, engine model busy 40 cycles each. Required: three eng_run pulses; sram_read_address=eng_read_address+0x000/0x020/0x040; sram_write_address=eng_write_address+0x100/0x110/0x120; batch_done pulse after the third busy fall; job_idx=2; no errors.
- cfg_job_count=0 -> batch_done 2 cycles after host_run, eng_run never asserted, host_busy high for 1 cycle.
- Engine never raises busy -> err_timeout=1 after ACK_MAX=4 cycles in WAIT_ACK, batch_done pulse, host_busy=0.
- Engine busy stuck high -> err_timeout at cycle 2047 of RUN, batch_done pulse; a following host_run clears err_timeout and restarts.
- host_abort during job 1 of 4 -> job 1 runs to busy fall, no further eng_run, err_abort=1, job_idx=1. host_run pulses during the batch are ignored.
- Base wrap: in_base=0xFF0, in_stride=0x020, 2 jobs -> job 1 base 0x010. eng_write_enable pulsed while IDLE -> sram_write_enable stays 0. Assert reset_b mid-RUN -> all outputs 0 immediately.

Source files
------------

// File: rtl/conv_batch_sched_if.sv
// Host, engine and SRAM signal bundle for the convolution batch scheduler.
// Ports: host_* batch control/status, cfg_* batch geometry, eng_* engine
//        handshake and engine-relative bus, sram_* relocated SRAM bus.
// slave = scheduler view, master = surrounding host/engine/SRAM view.
interface conv_batch_sched_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int JOB_W  = 4
) ();
  logic              host_run;
  logic              host_abort;
  logic              host_busy;
  logic [JOB_W-1:0]  cfg_job_count;
  logic [ADDR_W-1:0] cfg_in_base;
  logic [ADDR_W-1:0] cfg_out_base;
  logic [ADDR_W-1:0] cfg_in_stride;
  logic [ADDR_W-1:0] cfg_out_stride;
  logic              eng_run;
  logic              eng_busy;
  logic [ADDR_W-1:0] eng_read_address;
  logic [ADDR_W-1:0] eng_write_address;
  logic              eng_write_enable;
  logic [DATA_W-1:0] eng_write_data;
  logic [ADDR_W-1:0] sram_read_address;
  logic [ADDR_W-1:0] sram_write_address;
  logic              sram_write_enable;
  logic [DATA_W-1:0] sram_write_data;
  logic [JOB_W-1:0]  job_idx;
  logic              batch_done;
  logic              err_timeout;
  logic              err_abort;

  modport slave (
    input  host_run, host_abort, cfg_job_count, cfg_in_base, cfg_out_base,
           cfg_in_stride, cfg_out_stride, eng_busy, eng_read_address,
           eng_write_address, eng_write_enable, eng_write_data,
    output host_busy, eng_run, sram_read_address, sram_write_address,
           sram_write_enable, sram_write_data, job_idx, batch_done,
           err_timeout, err_abort
  );

  modport master (
    output host_run, host_abort, cfg_job_count, cfg_in_base, cfg_out_base,
           cfg_in_stride, cfg_out_stride, eng_busy, eng_read_address,
           eng_write_address, eng_write_enable, eng_write_data,
    input  host_busy, eng_run, sram_read_address, sram_write_address,
           sram_write_enable, sram_write_data, job_idx, batch_done,
           err_timeout, err_abort
  );
endinterface

// File: rtl/conv_batch_sched.sv
// Batch scheduler: launches the conv engine once per job, relocating its SRAM addresses per job.
// Latency: address/data path is combinational (0 cycles); control outputs come from registers.
// Backpressure: none on the host; each job waits on the engine run/busy handshake with ack/run timeouts.
// Ports: clk, reset_b (async active-low), bus (conv_batch_sched_if.slave) carrying host control,
//        cfg_* geometry, engine handshake/bus in, relocated SRAM bus out, job_idx and status flags.
module conv_batch_sched #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 16,
  parameter int JOB_W   = 4,
  parameter int ACK_MAX = 4,
  parameter int TIMEOUT = 2048
) (
  input  logic              clk,
  input  logic              reset_b,
  conv_batch_sched_if.slave bus
);
  localparam int ACK_W = $clog2(ACK_MAX + 1);
  localparam int RUN_W = $clog2(TIMEOUT);
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_MAX - 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_ACK, RUN, NEXT, DONE} state_t;

  state_t            state, state_nxt;
  logic [JOB_W-1:0]  job_cnt;
  logic [JOB_W-1:0]  job_idx;
  logic [ADDR_W-1:0] in_stride, out_stride;
  logic [ADDR_W-1:0] cur_in_base, cur_out_base;
  logic [ACK_W-1:0]  ack_cnt;
  logic [RUN_W-1:0]  run_cnt;
  logic              abort_pend;
  logic              err_tmo, err_abt, done_q;
  logic [DATA_W-1:0] wr_dat;

  // FSM control strobes
  logic accept, advance, set_tmo, set_abt;
  logic abort_any, last_job;
  logic [JOB_W:0] idx_inc;

  assign idx_inc   = {1'b0, job_idx} + {{JOB_W{1'b0}}, 1'b1};
  assign last_job  = (idx_inc == {1'b0, job_cnt});
  // An abort request seen this very cycle counts as pending.
  assign abort_any = abort_pend | bus.host_abort;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    advance   = 1'b0;
    set_tmo   = 1'b0;
    set_abt   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.host_run) begin
          accept    = 1'b1;
          state_nxt = (bus.cfg_job_count == '0) ? DONE : LAUNCH;
        end
      end
      LAUNCH: state_nxt = WAIT_ACK;
      WAIT_ACK: begin
        // A late ack in the final allowed cycle still wins over the timeout.
        if (bus.eng_busy) begin
          state_nxt = RUN;
        end else if (ack_cnt == ACK_LAST) begin
          set_tmo   = 1'b1;
          state_nxt = DONE;
        end
      end
      RUN: begin
        // Busy falling takes priority over the run timeout.
        if (!bus.eng_busy) begin
          if (abort_any) begin
            set_abt   = 1'b1;
            state_nxt = DONE;
          end else begin
            state_nxt = NEXT;
          end
        end else if (run_cnt == RUN_LAST) begin
          set_tmo   = 1'b1;
          state_nxt = DONE;
        end
      end
      NEXT: begin
        if (abort_any) begin
          set_abt   = 1'b1;
          state_nxt = DONE;
        end else if (last_job) begin
          state_nxt = DONE;
        end else begin
          advance   = 1'b1;
          state_nxt = LAUNCH;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      job_cnt      <= '0;
      job_idx      <= '0;
      in_stride    <= '0;
      out_stride   <= '0;
      cur_in_base  <= '0;
      cur_out_base <= '0;
      ack_cnt      <= '0;
      run_cnt      <= '0;
      abort_pend   <= 1'b0;
      err_tmo      <= 1'b0;
      err_abt      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      // Done pulses on the edge that leaves DONE, together with host_busy falling.
      done_q  <= (state == DONE);
      ack_cnt <= (state == WAIT_ACK) ? ack_cnt + 1'b1 : '0;
      run_cnt <= (state == RUN) ? run_cnt + 1'b1 : '0;

      if (accept || state == DONE) abort_pend <= 1'b0;
      else if (state != IDLE && bus.host_abort) abort_pend <= 1'b1;

      if (accept) begin
        job_cnt      <= bus.cfg_job_count;
        in_stride    <= bus.cfg_in_stride;
        out_stride   <= bus.cfg_out_stride;
        cur_in_base  <= bus.cfg_in_base;
        cur_out_base <= bus.cfg_out_base;
        job_idx      <= '0;
        err_tmo      <= 1'b0;
        err_abt      <= 1'b0;
      end else begin
        // Bases only move between jobs, never while the engine is busy.
        if (advance) begin
          job_idx      <= idx_inc[JOB_W-1:0];
          cur_in_base  <= cur_in_base + in_stride;
          cur_out_base <= cur_out_base + out_stride;
        end
        if (set_tmo) err_tmo <= 1'b1;
        if (set_abt) err_abt <= 1'b1;
      end
    end
  end

  assign wr_dat                 = bus.eng_write_data;
  assign bus.sram_write_data    = wr_dat;
  assign bus.sram_read_address  = bus.eng_read_address + cur_in_base;
  assign bus.sram_write_address = bus.eng_write_address + cur_out_base;
  // Stray engine writes while no batch is active never reach the SRAM.
  assign bus.sram_write_enable  = bus.eng_write_enable & (state != IDLE);
  assign bus.host_busy          = (state != IDLE);
  assign bus.eng_run            = (state == LAUNCH);
  assign bus.batch_done         = done_q;
  assign bus.job_idx            = job_idx;
  assign bus.err_timeout        = err_tmo;
  assign bus.err_abort          = err_abt;
endmodule

// File: tb/tb_conv_batch_sched.sv
module tb_conv_batch_sched;
  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 16;
  localparam int JOB_W   = 4;
  localparam int ACK_MAX = 4;
  localparam int TIMEOUT = 2048;

  logic clk = 1'b0;
  logic reset_b;
  always #5 clk = ~clk;

  conv_batch_sched_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .JOB_W(JOB_W)) bus ();

  conv_batch_sched #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .JOB_W(JOB_W), .ACK_MAX(ACK_MAX), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset_b(reset_b),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Engine behaviour knobs: mode 0 normal, 1 never acks, 2 busy stuck high.
  int eng_mode = 0;
  int ack_dly  = 0;
  int run_len  = 40;
  bit force_we = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural engine: acks eng_run after ack_dly cycles, stays busy run_len cycles,
  // wanders its addresses every cycle. Shares reset_b with the scheduler.
  initial begin : engine
    int  e_wait;
    int  e_left;
    bit  e_pend;
    e_wait = 0; e_left = 0; e_pend = 1'b0;
    bus.eng_busy = 1'b0; bus.eng_read_address = '0; bus.eng_write_address = '0;
    bus.eng_write_enable = 1'b0; bus.eng_write_data = '0;
    forever begin
      @(posedge clk or negedge reset_b);
      if (!reset_b) begin
        e_pend = 1'b0;
        bus.eng_busy = 1'b0; bus.eng_read_address = '0; bus.eng_write_address = '0;
        bus.eng_write_enable = 1'b0; bus.eng_write_data = '0;
      end else begin
        #1;
        if (bus.eng_busy) begin
          if (eng_mode != 2) begin
            e_left--;
            if (e_left <= 0) bus.eng_busy = 1'b0;
          end
        end else begin
          if (bus.eng_run && eng_mode != 1) begin
            e_pend = 1'b1;
            e_wait = ack_dly;
          end
          if (e_pend) begin
            if (e_wait == 0) begin
              bus.eng_busy = 1'b1;
              e_left = run_len;
              e_pend = 1'b0;
            end else begin
              e_wait--;
            end
          end
        end
        bus.eng_read_address  = ADDR_W'($urandom);
        bus.eng_write_address = ADDR_W'($urandom);
        bus.eng_write_data    = DATA_W'($urandom);
        bus.eng_write_enable  = (bus.eng_busy & 1'($urandom)) | force_we;
      end
    end
  end

  task automatic rand_cfg();
    bus.cfg_job_count  = JOB_W'($urandom);
    bus.cfg_in_base    = ADDR_W'($urandom);
    bus.cfg_out_base   = ADDR_W'($urandom);
    bus.cfg_in_stride  = ADDR_W'($urandom);
    bus.cfg_out_stride = ADDR_W'($urandom);
  endtask

  // Launches a batch and follows it to batch_done. While the engine is busy the
  // relocated bus is checked against base + job*stride (mod 4096).
  task automatic run_batch(input int n, input logic [11:0] ib, input logic [11:0] is,
                           input logic [11:0] ob, input logic [11:0] os,
                           input int abort_job, input bit noise, input int budget,
                           output int runs, output int cycles, output int busy_cyc,
                           output logic [11:0] last_off);
    int k;
    int job_busy;
    bit done;
    logic [11:0] ei, eo;
    runs = 0; cycles = 0; busy_cyc = 0; last_off = '0; job_busy = 0; done = 1'b0;
    @(negedge clk);
    bus.cfg_job_count  = JOB_W'(n);
    bus.cfg_in_base    = ib;
    bus.cfg_in_stride  = is;
    bus.cfg_out_base   = ob;
    bus.cfg_out_stride = os;
    bus.host_run       = 1'b1;
    while (!done && cycles < budget) begin
      @(negedge clk);
      cycles++;
      bus.host_run   = 1'b0;
      bus.host_abort = 1'b0;
      if (cycles == 1) begin
        chk("start_err_timeout", 32'(bus.err_timeout), 32'd0);
        chk("start_err_abort", 32'(bus.err_abort), 32'd0);
        chk("start_host_busy", 32'(bus.host_busy), 32'd1);
      end
      if (bus.host_busy) busy_cyc++;
      if (bus.eng_run) begin
        runs++;
        job_busy = 0;
      end
      if (bus.eng_busy && bus.host_busy && runs > 0) begin
        k  = runs - 1;
        ei = 12'((int'(ib) + k * int'(is)) % 4096);
        eo = 12'((int'(ob) + k * int'(os)) % 4096);
        chk("rd_addr", 32'(bus.sram_read_address), 32'(12'(bus.eng_read_address + ei)));
        chk("wr_addr", 32'(bus.sram_write_address), 32'(12'(bus.eng_write_address + eo)));
        chk("wr_en", 32'(bus.sram_write_enable), 32'(bus.eng_write_enable));
        chk("wr_data", 32'(bus.sram_write_data), 32'(bus.eng_write_data));
        chk("job_idx_run", 32'(bus.job_idx), 32'(k));
        last_off = bus.sram_read_address - bus.eng_read_address;
        job_busy++;
        if (k == abort_job && job_busy == 10) bus.host_abort = 1'b1;
      end
      if (bus.batch_done) begin
        done = 1'b1;
      end else if (noise && (cycles % 7) == 3) begin
        bus.host_run = 1'b1;
        rand_cfg();
      end
    end
    if (!done) chk("batch_done_seen", 32'd0, 32'd1);
  endtask

  // Status at the batch_done cycle, then the pulse must end one cycle later.
  task automatic end_checks(input string tag, input int runs, input int exp_runs,
                            input int exp_idx, input bit exp_t, input bit exp_a);
    chk({tag, "_runs"}, 32'(runs), 32'(exp_runs));
    chk({tag, "_host_busy"}, 32'(bus.host_busy), 32'd0);
    chk({tag, "_job_idx"}, 32'(bus.job_idx), 32'(exp_idx));
    chk({tag, "_err_timeout"}, 32'(bus.err_timeout), 32'(exp_t));
    chk({tag, "_err_abort"}, 32'(bus.err_abort), 32'(exp_a));
    @(negedge clk);
    chk({tag, "_done_pulse_end"}, 32'(bus.batch_done), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctrl"}, {26'd0, bus.host_busy, bus.eng_run, bus.batch_done,
                         bus.err_timeout, bus.err_abort, bus.sram_write_enable}, 32'd0);
    chk({tag, "_job_idx"}, 32'(bus.job_idx), 32'd0);
    chk({tag, "_rd_addr"}, 32'(bus.sram_read_address), 32'd0);
    chk({tag, "_wr_addr"}, 32'(bus.sram_write_address), 32'd0);
    chk({tag, "_wr_data"}, 32'(bus.sram_write_data), 32'd0);
  endtask

  initial begin : stimulus
    int runs, cycles, busy_cyc, n, guard;
    logic [11:0] off;
    bit reached;
    reset_b = 1'b0;
    bus.host_run = 1'b0; bus.host_abort = 1'b0;
    rand_cfg();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_b = 1'b1;
    repeat (2) @(negedge clk);

    // Three-job batch with the documented geometry.
    eng_mode = 0; ack_dly = 1; run_len = 40;
    run_batch(3, 12'h000, 12'h020, 12'h100, 12'h010, -1, 1'b0, 1000, runs, cycles, busy_cyc, off);
    end_checks("batch3", runs, 3, 2, 1'b0, 1'b0);
    chk("batch3_last_off", 32'(off), 32'h040);

    // Empty batch: done two cycles after host_run, busy for one cycle, no launch.
    run_batch(0, 12'h123, 12'h001, 12'h456, 12'h001, -1, 1'b0, 20, runs, cycles, busy_cyc, off);
    chk("zero_latency", 32'(cycles), 32'd2);
    chk("zero_busy_cycles", 32'(busy_cyc), 32'd1);
    end_checks("zero", runs, 0, 0, 1'b0, 1'b0);

    // Engine never acknowledges: LAUNCH + ACK_MAX wait cycles + DONE, then the pulse.
    eng_mode = 1;
    run_batch(2, 12'h010, 12'h010, 12'h200, 12'h010, -1, 1'b0, 50, runs, cycles, busy_cyc, off);
    chk("ack_tmo_latency", 32'(cycles), 32'(ACK_MAX + 3));
    end_checks("ack_tmo", runs, 1, 0, 1'b1, 1'b0);

    // Engine busy stuck high: run timeout after TIMEOUT cycles of RUN.
    eng_mode = 2; ack_dly = 0; run_len = 20;
    run_batch(1, 12'h080, 12'h000, 12'h300, 12'h000, -1, 1'b0, TIMEOUT + 100, runs, cycles, busy_cyc, off);
    chk("run_tmo_latency", 32'(cycles), 32'(TIMEOUT + 4));
    end_checks("run_tmo", runs, 1, 0, 1'b1, 1'b0);
    eng_mode = 0;
    repeat (40) @(negedge clk);
    run_batch(1, 12'h040, 12'h000, 12'h340, 12'h000, -1, 1'b0, 200, runs, cycles, busy_cyc, off);
    end_checks("restart", runs, 1, 0, 1'b0, 1'b0);

    // Abort during job 1 of 4 while host_run is pulsed with junk config.
    ack_dly = 2; run_len = 30;
    run_batch(4, 12'h100, 12'h040, 12'h800, 12'h020, 1, 1'b1, 1000, runs, cycles, busy_cyc, off);
    end_checks("abort", runs, 2, 1, 1'b0, 1'b1);

    // Random geometry batches against the arithmetic model.
    for (int t = 0; t < 4; t++) begin
      n = $urandom_range(1, 5);
      ack_dly = $urandom_range(0, 2);
      run_len = $urandom_range(5, 25);
      run_batch(n, 12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom), -1,
                1'($urandom), 1000, runs, cycles, busy_cyc, off);
      end_checks("random", runs, n, n - 1, 1'b0, 1'b0);
    end

    // Base wraps modulo 4096.
    ack_dly = 0; run_len = 12;
    run_batch(2, 12'hFF0, 12'h020, 12'h000, 12'h001, -1, 1'b0, 200, runs, cycles, busy_cyc, off);
    chk("wrap_base_job1", 32'(off), 32'h010);
    end_checks("wrap", runs, 2, 1, 1'b0, 1'b0);

    // Engine write strobe while idle never reaches the SRAM.
    force_we = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_we_gate", 32'(bus.sram_write_enable), 32'd0);
    end
    force_we = 1'b0;

    // Reset asserted while job 1 is running.
    run_len = 40; ack_dly = 1;
    @(negedge clk);
    bus.cfg_job_count = 4'd3; bus.cfg_in_base = 12'h200; bus.cfg_in_stride = 12'h030;
    bus.cfg_out_base = 12'h500; bus.cfg_out_stride = 12'h030;
    bus.host_run = 1'b1;
    runs = 0; guard = 0; reached = 1'b0;
    while (!reached && guard < 500) begin
      @(negedge clk);
      guard++;
      bus.host_run = 1'b0;
      if (bus.eng_run) runs++;
      if (runs == 2 && bus.eng_busy) reached = 1'b1;
    end
    chk("midrst_reached_job1", 32'(reached), 32'd1);
    chk("midrst_job_idx_before", 32'(bus.job_idx), 32'd1);
    reset_b = 1'b0;
    #1;
    check_all_zero("midrst");
    repeat (2) @(negedge clk);
    reset_b = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", {30'd0, bus.host_busy, bus.eng_run}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
